branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Closes the loop on the IF-stage branch target buffer lookup.
- Carries each fetched instruction's prediction metadata through ID to EX, then compares it with the actual branch outcome.
- On a wrong prediction it raises a redirect with the correct PC.
- One cycle after every resolution it drives the BTB write port: index, tag, target, valid flag and 2-bit counter.
- It also keeps branch and mispredict statistics.

Parameters:
- XLEN, 32, width of PC and target values
- IDX_W, 8, BTB index width; index = pc[IDX_W+1:2]
- TAG_W, 4, BTB tag width; tag = pc[IDX_W+TAG_W+1:IDX_W+2]
- CNT_W, 32, width of the statistics counters

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous reset, active-low
- stall_i  in  1  pipeline stall; holds both metadata stages and blocks resolution
- if_valid_i  in  1  IF holds a real instruction
- if_pc_i  in  XLEN  PC of the IF instruction
- pred_hit_i  in  1  BTB entry valid and tag match
- pred_ctr_i  in  2  BTB counter read for if_pc_i
- pred_target_i  in  XLEN  BTB predicted target
- ex_is_br_i  in  1  EX instruction is a branch or jump
- ex_taken_i  in  1  actual direction (br_comp result)
- ex_target_i  in  XLEN  actual target (pc+imm / jalr)
- redirect_o  out  1  mispredict; flush IF/ID and load redirect_pc_o
- redirect_pc_o  out  XLEN  correct next PC
- btb_we_o  out  1  BTB write strobe (1-cycle pulse)
- btb_idx_o  out  IDX_W  BTB write index
- btb_tag_o  out  TAG_W  BTB write tag
- btb_target_o  out  XLEN  BTB write target
- btb_valid_o  out  1  flag bit to store (0 = invalidate)
- btb_ctr_o  out  2  counter to store
- br_cnt_o  out  CNT_W  resolved branches
- mispred_cnt_o  out  CNT_W  redirects issued

Behaviour:
- Metadata record: {valid, pc, hit, ctr, target}. There are two register stages, ID and EX.
- When stall_i=0: ID <= {if_valid_i, if_pc_i, pred_*}, and EX <= ID.
- When stall_i=1: ID and EX hold their values.
- Predicted-taken: pt = EX.hit & EX.ctr[1]. Predicted next PC = pt ? EX.target : EX.pc+4, with modulo-2^XLEN wrap.
- Resolution event R = EX.valid & ~stall_i.
- Actual next PC:
  - ex_is_br_i=1: ex_taken_i ? ex_target_i : EX.pc+4.
  - ex_is_br_i=0: EX.pc+4.
- redirect_o = R & (actual next PC != predicted next PC). It is combinational. redirect_pc_o = actual next PC whenever R, otherwise 0.
- On redirect_o=1, the next edge clears ID.valid and EX.valid. This overrides the normal capture, and the IF-cycle metadata is discarded.
- BTB update decision, taken at R and registered; the btb_* outputs appear exactly 1 cycle later:
  - Branch, hit: write; ctr = saturating ctr+1 if taken, saturating ctr-1 if not taken. 11 stays 11, 00 stays 00. valid=1. target = ex_target_i if taken, else EX.target.
  - Branch, miss, taken: write; ctr=10, valid=1, target=ex_target_i.
  - Branch, miss, not taken: no write.
  - Non-branch with hit (alias): write; valid=0, ctr=00, target=0.
  - Non-branch without hit: no write.
- btb_idx_o and btb_tag_o are derived from EX.pc.
- When btb_we_o=0, all btb_* outputs hold 0.
- btb_we_o never asserts in two consecutive cycles unless R occurs in two consecutive cycles. Back-to-back updates are allowed; each is a 1-cycle pulse.
- Counters:
  - br_cnt_o += 1 on R & ex_is_br_i.
  - mispred_cnt_o += 1 on redirect_o.
  - Both saturate at all-ones.
- Reset (rst_ni=0 at an edge): all stage registers, pending update, counters and outputs go to 0.
  - A pending BTB write is dropped.
  - redirect_o is 0 while rst_ni=0.

Test Plan:
- Miss, branch taken: pc 0x100 fetched with hit=0, EX sees is_br=1, taken=1, target=0x140 -> redirect_o=1, redirect_pc_o=0x140. Next cycle btb_we_o=1, idx=0x40, tag=0x0, target=0x140, ctr=10, valid=1. mispred_cnt_o=1.
- Hit, correct prediction: pc 0x100 with hit=1, ctr=10, target=0x140, actual taken to 0x140 -> redirect_o=0. Next cycle btb_we_o=1 with ctr=11. A repeat with ctr=11 writes ctr=11 (saturation).
- Hit, predicted taken, actually not taken: pc 0x2004, ctr=11 -> redirect_pc_o=0x2008, then ctr=10. Starting from ctr=00 and not taken -> no redirect, written ctr=00.
- Alias: hit=1, ctr=11 on a non-branch at pc 0x300 -> redirect_pc_o=0x304, btb_valid_o=0, btb_ctr_o=00, br_cnt_o unchanged.
- Stall: hold stall_i=1 for 3 cycles with a mispredicting EX entry -> redirect_o=0 and no btb_we_o during the stall. Resolution happens on the first cycle after release. Younger entries in ID are killed after the redirect (valid=0, no second update).
- Reset mid-operation: assert rst_ni=0 in the cycle between resolution and write-back -> btb_we_o stays 0, and both counters and all outputs read 0.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch resolution: carries BTB prediction metadata IF->ID->EX, detects
// mispredicts, issues redirects, schedules the BTB write-back and keeps stats.
module branch_resolve_unit #(
    parameter int XLEN  = 32,
    parameter int IDX_W = 8,
    parameter int TAG_W = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             stall_i,
    input  logic             if_valid_i,
    input  logic [XLEN-1:0]  if_pc_i,
    input  logic             pred_hit_i,
    input  logic [1:0]       pred_ctr_i,
    input  logic [XLEN-1:0]  pred_target_i,
    input  logic             ex_is_br_i,
    input  logic             ex_taken_i,
    input  logic [XLEN-1:0]  ex_target_i,
    output logic             redirect_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic             btb_we_o,
    output logic [IDX_W-1:0] btb_idx_o,
    output logic [TAG_W-1:0] btb_tag_o,
    output logic [XLEN-1:0]  btb_target_o,
    output logic             btb_valid_o,
    output logic [1:0]       btb_ctr_o,
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    logic            id_v_q, ex_v_q;
    logic [XLEN-1:0] id_pc_q, ex_pc_q;
    logic            id_hit_q, ex_hit_q;
    logic [1:0]      id_ctr_q, ex_ctr_q;
    logic [XLEN-1:0] id_tgt_q, ex_tgt_q;

    logic            res, pt;
    logic [XLEN-1:0] seq_pc, pred_pc, act_pc;

    logic             we_d, valid_d;
    logic [1:0]       ctr_d;
    logic [XLEN-1:0]  tgt_d;
    logic [IDX_W-1:0] idx_d;
    logic [TAG_W-1:0] tag_d;
    logic [CNT_W-1:0] br_cnt_d, mis_cnt_d;

    always_comb begin
        seq_pc        = ex_pc_q + XLEN'(4);
        pt            = ex_hit_q & ex_ctr_q[1];
        pred_pc       = pt ? ex_tgt_q : seq_pc;
        act_pc        = (ex_is_br_i && ex_taken_i) ? ex_target_i : seq_pc;
        res           = rst_ni & ex_v_q & ~stall_i;
        redirect_o    = res & (act_pc != pred_pc);
        redirect_pc_o = res ? act_pc : '0;
    end

    // BTB write-back decision; a non-branch hit is an alias and is invalidated
    always_comb begin
        we_d    = 1'b0;
        valid_d = 1'b0;
        ctr_d   = 2'b00;
        tgt_d   = '0;
        if (res) begin
            if (ex_is_br_i) begin
                if (ex_hit_q) begin
                    we_d    = 1'b1;
                    valid_d = 1'b1;
                    if (ex_taken_i) begin
                        ctr_d = (ex_ctr_q == 2'b11) ? 2'b11 : ex_ctr_q + 2'd1;
                        tgt_d = ex_target_i;
                    end else begin
                        ctr_d = (ex_ctr_q == 2'b00) ? 2'b00 : ex_ctr_q - 2'd1;
                        tgt_d = ex_tgt_q;
                    end
                end else if (ex_taken_i) begin
                    we_d    = 1'b1;
                    valid_d = 1'b1;
                    ctr_d   = 2'b10;
                    tgt_d   = ex_target_i;
                end
            end else if (ex_hit_q) begin
                we_d = 1'b1;
            end
        end
        idx_d = we_d ? ex_pc_q[IDX_W+1:2] : '0;
        tag_d = we_d ? ex_pc_q[IDX_W+TAG_W+1:IDX_W+2] : '0;
    end

    always_comb begin
        br_cnt_d  = br_cnt_o;
        mis_cnt_d = mispred_cnt_o;
        if (res && ex_is_br_i && br_cnt_o != '1)
            br_cnt_d = br_cnt_o + CNT_W'(1);
        if (redirect_o && mispred_cnt_o != '1)
            mis_cnt_d = mispred_cnt_o + CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            id_v_q        <= 1'b0;
            id_pc_q       <= '0;
            id_hit_q      <= 1'b0;
            id_ctr_q      <= 2'b00;
            id_tgt_q      <= '0;
            ex_v_q        <= 1'b0;
            ex_pc_q       <= '0;
            ex_hit_q      <= 1'b0;
            ex_ctr_q      <= 2'b00;
            ex_tgt_q      <= '0;
            btb_we_o      <= 1'b0;
            btb_idx_o     <= '0;
            btb_tag_o     <= '0;
            btb_target_o  <= '0;
            btb_valid_o   <= 1'b0;
            btb_ctr_o     <= 2'b00;
            br_cnt_o      <= '0;
            mispred_cnt_o <= '0;
        end else begin
            if (redirect_o) begin
                id_v_q <= 1'b0;
                ex_v_q <= 1'b0;
            end else if (!stall_i) begin
                id_v_q   <= if_valid_i;
                id_pc_q  <= if_pc_i;
                id_hit_q <= pred_hit_i;
                id_ctr_q <= pred_ctr_i;
                id_tgt_q <= pred_target_i;
                ex_v_q   <= id_v_q;
                ex_pc_q  <= id_pc_q;
                ex_hit_q <= id_hit_q;
                ex_ctr_q <= id_ctr_q;
                ex_tgt_q <= id_tgt_q;
            end
            btb_we_o      <= we_d;
            btb_idx_o     <= idx_d;
            btb_tag_o     <= tag_d;
            btb_target_o  <= tgt_d;
            btb_valid_o   <= valid_d;
            btb_ctr_o     <= ctr_d;
            br_cnt_o      <= br_cnt_d;
            mispred_cnt_o <= mis_cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: vector table plus stall and
// mid-update reset sequences.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst_ni, stall_i, if_valid_i, pred_hit_i;
    logic [31:0] if_pc_i, pred_target_i, ex_target_i;
    logic [1:0]  pred_ctr_i;
    logic        ex_is_br_i, ex_taken_i;
    logic        redirect_o, btb_we_o, btb_valid_o;
    logic [31:0] redirect_pc_o, btb_target_o, br_cnt_o, mispred_cnt_o;
    logic [7:0]  btb_idx_o;
    logic [3:0]  btb_tag_o;
    logic [1:0]  btb_ctr_o;

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk_i(clk), .rst_ni(rst_ni), .stall_i(stall_i),
        .if_valid_i(if_valid_i), .if_pc_i(if_pc_i),
        .pred_hit_i(pred_hit_i), .pred_ctr_i(pred_ctr_i),
        .pred_target_i(pred_target_i), .ex_is_br_i(ex_is_br_i),
        .ex_taken_i(ex_taken_i), .ex_target_i(ex_target_i),
        .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
        .btb_we_o(btb_we_o), .btb_idx_o(btb_idx_o), .btb_tag_o(btb_tag_o),
        .btb_target_o(btb_target_o), .btb_valid_o(btb_valid_o),
        .btb_ctr_o(btb_ctr_o), .br_cnt_o(br_cnt_o),
        .mispred_cnt_o(mispred_cnt_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic        hit;
        logic [1:0]  ctr;
        logic [31:0] ptgt;
        logic        is_br;
        logic        taken;
        logic [31:0] atgt;
        logic        e_red;
        logic [31:0] e_rpc;
        logic        e_we;
        logic [7:0]  e_idx;
        logic [3:0]  e_tag;
        logic [31:0] e_tgt;
        logic        e_val;
        logic [1:0]  e_ctr;
    } vec_t;

    vec_t vt[11];
    int total = 0;
    int bad = 0;
    int m_br = 0;
    int m_mis = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle_in();
        if_valid_i = 0; if_pc_i = 0; pred_hit_i = 0; pred_ctr_i = 0;
        pred_target_i = 0; ex_is_br_i = 0; ex_taken_i = 0; ex_target_i = 0;
    endtask

    task automatic load_if(input logic [31:0] pc, input logic hit,
                           input logic [1:0] ctr, input logic [31:0] tgt);
        if_valid_i = 1; if_pc_i = pc; pred_hit_i = hit;
        pred_ctr_i = ctr; pred_target_i = tgt;
    endtask

    task automatic chk_btb_zero(input string nm);
        chk({nm, "_we"}, 32'(btb_we_o), 0);
        chk({nm, "_fields"}, {btb_target_o[23:0], btb_idx_o}, 0);
        chk({nm, "_misc"}, {26'd0, btb_tag_o, btb_valid_o, btb_ctr_o[0] | btb_ctr_o[1]}, 0);
    endtask

    initial begin
        vt[0]  = '{32'h100, 0, 2'd0, 32'h0, 1, 1, 32'h140, 1, 32'h140, 1, 8'h40, 4'h0, 32'h140, 1, 2'd2};
        vt[1]  = '{32'h100, 1, 2'd2, 32'h140, 1, 1, 32'h140, 0, 32'h140, 1, 8'h40, 4'h0, 32'h140, 1, 2'd3};
        vt[2]  = '{32'h100, 1, 2'd3, 32'h140, 1, 1, 32'h140, 0, 32'h140, 1, 8'h40, 4'h0, 32'h140, 1, 2'd3};
        vt[3]  = '{32'h2004, 1, 2'd3, 32'h2100, 1, 0, 32'h2100, 1, 32'h2008, 1, 8'h01, 4'h8, 32'h2100, 1, 2'd2};
        vt[4]  = '{32'h2004, 1, 2'd0, 32'h2100, 1, 0, 32'h2100, 0, 32'h2008, 1, 8'h01, 4'h8, 32'h2100, 1, 2'd0};
        vt[5]  = '{32'h300, 1, 2'd3, 32'h400, 0, 0, 32'h0, 1, 32'h304, 1, 8'hC0, 4'h0, 32'h0, 0, 2'd0};
        vt[6]  = '{32'h500, 0, 2'd0, 32'h0, 1, 0, 32'h580, 0, 32'h504, 0, 8'h0, 4'h0, 32'h0, 0, 2'd0};
        vt[7]  = '{32'h600, 0, 2'd0, 32'h0, 0, 0, 32'h0, 0, 32'h604, 0, 8'h0, 4'h0, 32'h0, 0, 2'd0};
        vt[8]  = '{32'h700, 1, 2'd1, 32'h780, 1, 1, 32'h800, 1, 32'h800, 1, 8'hC0, 4'h1, 32'h800, 1, 2'd2};
        vt[9]  = '{32'hFFFFFFFC, 1, 2'd2, 32'h10, 1, 1, 32'h10, 0, 32'h10, 1, 8'hFF, 4'hF, 32'h10, 1, 2'd3};
        vt[10] = '{32'h900, 1, 2'd2, 32'h940, 1, 1, 32'h980, 1, 32'h980, 1, 8'h40, 4'h2, 32'h980, 1, 2'd3};

        rst_ni = 0; stall_i = 0; idle_in();
        repeat (2) @(negedge clk);
        chk("rst_redirect", 32'(redirect_o), 0);
        chk("rst_rpc", redirect_pc_o, 0);
        chk_btb_zero("rst_btb");
        chk("rst_brcnt", br_cnt_o, 0);
        chk("rst_miscnt", mispred_cnt_o, 0);
        rst_ni = 1;

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            idle_in();
            load_if(vt[i].pc, vt[i].hit, vt[i].ctr, vt[i].ptgt);
            @(negedge clk);
            idle_in();
            @(negedge clk);
            ex_is_br_i = vt[i].is_br; ex_taken_i = vt[i].taken;
            ex_target_i = vt[i].atgt;
            #1;
            chk($sformatf("v%0d_redirect", i), 32'(redirect_o), 32'(vt[i].e_red));
            chk($sformatf("v%0d_rpc", i), redirect_pc_o, vt[i].e_rpc);
            if (vt[i].is_br) m_br++;
            if (vt[i].e_red) m_mis++;
            @(negedge clk);
            idle_in();
            #1;
            chk($sformatf("v%0d_we", i), 32'(btb_we_o), 32'(vt[i].e_we));
            chk($sformatf("v%0d_idx", i), 32'(btb_idx_o), 32'(vt[i].e_idx));
            chk($sformatf("v%0d_tag", i), 32'(btb_tag_o), 32'(vt[i].e_tag));
            chk($sformatf("v%0d_tgt", i), btb_target_o, vt[i].e_tgt);
            chk($sformatf("v%0d_valid", i), 32'(btb_valid_o), 32'(vt[i].e_val));
            chk($sformatf("v%0d_ctr", i), 32'(btb_ctr_o), 32'(vt[i].e_ctr));
            chk($sformatf("v%0d_brcnt", i), br_cnt_o, m_br);
            chk($sformatf("v%0d_miscnt", i), mispred_cnt_o, m_mis);
        end

        // stall with mispredicting EX entry, younger alias entry in ID
        @(negedge clk);
        idle_in();
        load_if(32'h100, 0, 2'd0, 32'h0);
        @(negedge clk);
        load_if(32'h104, 1, 2'd3, 32'h200);
        @(negedge clk);
        idle_in();
        stall_i = 1;
        ex_is_br_i = 1; ex_taken_i = 1; ex_target_i = 32'h140;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall%0d_redirect", k), 32'(redirect_o), 0);
            chk($sformatf("stall%0d_we", k), 32'(btb_we_o), 0);
            @(negedge clk);
        end
        stall_i = 0;
        #1;
        chk("rel_redirect", 32'(redirect_o), 1);
        chk("rel_rpc", redirect_pc_o, 32'h140);
        m_br++; m_mis++;
        @(negedge clk);
        ex_is_br_i = 0; ex_taken_i = 0; ex_target_i = 0;
        #1;
        chk("rel_we", 32'(btb_we_o), 1);
        chk("rel_ctr", 32'(btb_ctr_o), 2);
        chk("rel_tgt", btb_target_o, 32'h140);
        chk("kill_redirect", 32'(redirect_o), 0);
        @(negedge clk);
        #1;
        chk("kill_we", 32'(btb_we_o), 0);
        chk("kill_redirect2", 32'(redirect_o), 0);
        chk("stall_brcnt", br_cnt_o, m_br);
        chk("stall_miscnt", mispred_cnt_o, m_mis);

        // reset lands on the resolution edge: pending write dropped
        @(negedge clk);
        idle_in();
        load_if(32'h100, 0, 2'd0, 32'h0);
        @(negedge clk);
        idle_in();
        @(negedge clk);
        ex_is_br_i = 1; ex_taken_i = 1; ex_target_i = 32'h140;
        #1;
        chk("pre_rst_redirect", 32'(redirect_o), 1);
        rst_ni = 0;
        #1;
        chk("in_rst_redirect", 32'(redirect_o), 0);
        @(negedge clk);
        idle_in();
        #1;
        chk_btb_zero("post_rst");
        chk("post_rst_brcnt", br_cnt_o, 0);
        chk("post_rst_miscnt", mispred_cnt_o, 0);
        chk("post_rst_rpc", redirect_pc_o, 0);
        rst_ni = 1;
        @(negedge clk);
        #1;
        chk_btb_zero("post_rst2");
        chk("post_rst2_redirect", 32'(redirect_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
